adc_frame_aligner: RTL

//  Consumes per-lane DDR bit pairs (rise/fall) from the lane capture stage and assembles them into ADC sample words.

---
 rtl/adc_frame_aligner.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/adc_frame_aligner.sv
// Builds ADC sample words from per-lane DDR bit pairs. The word window bit-slips
// until the frame lane shows FRAME_PATTERN, and data words are emitted while locked.
module adc_frame_aligner #(
   parameter int              LANES         = 8,
   parameter int              BITS          = 8,
   parameter int              FRAME_LANE    = LANES-1,
   parameter logic [BITS-1:0] FRAME_PATTERN = 8'hF0,
   parameter int              LOCK_COUNT    = 4,
   parameter int              UNLOCK_COUNT  = 4,
   parameter int              SETTLE        = 2
) (
   input  logic                        dco_clk,
   input  logic                        rst,
   input  logic [LANES-1:0]            rise,
   input  logic [LANES-1:0]            fall,
   input  logic                        realign,
   output logic [(LANES-1)*BITS-1:0]   words,
   output logic                        word_valid,
   output logic                        locked,
   output logic                        frame_err,
   output logic [$clog2(BITS)-1:0]     slip
);
   localparam int SW   = $clog2(BITS);
   localparam int PW   = $clog2(BITS/2);
   localparam int WW   = (LANES-1)*BITS;
   localparam int CMAX = (LOCK_COUNT > UNLOCK_COUNT) ?
                         ((LOCK_COUNT > SETTLE) ? LOCK_COUNT : SETTLE) :
                         ((UNLOCK_COUNT > SETTLE) ? UNLOCK_COUNT : SETTLE);
   localparam int CW   = $clog2(CMAX+1);

   typedef enum logic [1:0] {S_SEARCH, S_SETTLE, S_VERIFY, S_LOCKED} state_t;

   state_t                        state, state_nx;
   logic [CW-1:0]                 cnt, cnt_nx, cnt_inc;
   logic [SW-1:0]                 slip_nx, slip_inc;
   logic [PW-1:0]                 phase;
   logic [LANES-1:0][2*BITS-1:0]  hist;
   logic [LANES-1:0][BITS-1:0]    win;
   logic [WW-1:0]                 words_nx;
   logic                          tick, match, wv_nx, fe_nx;

   // Each cycle shifts in one DDR pair per lane; bit 0 is the newest bit.
   always_ff @(posedge dco_clk) begin
      if (rst) begin
         hist <= '0;
      end else begin
         for (int l = 0; l < LANES; l++)
            hist[l] <= {hist[l][2*BITS-3:0], rise[l], fall[l]};
      end
   end

   // Larger slip reaches further back in time; MSB of the window is the oldest bit.
   always_comb begin
      win = '0;
      for (int l = 0; l < LANES; l++)
         win[l] = hist[l][slip +: BITS];
   end

   always_comb begin
      words_nx = '0;
      for (int l = 0; l < LANES; l++) begin
         if (l < FRAME_LANE)      words_nx[l*BITS +: BITS]     = win[l];
         else if (l > FRAME_LANE) words_nx[(l-1)*BITS +: BITS] = win[l];
      end
   end

   assign tick     = (phase == '0);
   assign match    = (win[FRAME_LANE] == FRAME_PATTERN);
   assign cnt_inc  = cnt + 1'b1;
   assign slip_inc = (slip == SW'(BITS-1)) ? '0 : slip + 1'b1;

   always_ff @(posedge dco_clk) begin
      if (rst) begin
         state <= S_SEARCH;
         cnt   <= '0;
         slip  <= '0;
         phase <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         slip  <= slip_nx;
         phase <= (phase == PW'(BITS/2-1)) ? '0 : phase + 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      slip_nx  = slip;
      if (realign) begin
         state_nx = S_SEARCH;
         cnt_nx   = '0;
      end else if (tick) begin
         case (state)
            S_SEARCH, S_VERIFY: begin
               if (!match) begin
                  slip_nx  = slip_inc;
                  cnt_nx   = '0;
                  state_nx = S_SETTLE;
                  if (SETTLE == 0) state_nx = S_SEARCH;
               end else if (state == S_SEARCH && LOCK_COUNT != 1) begin
                  state_nx = S_VERIFY;
                  cnt_nx   = CW'(1);
               end else if (state == S_SEARCH || cnt_inc == CW'(LOCK_COUNT)) begin
                  state_nx = S_LOCKED;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
            S_SETTLE: begin
               if (cnt_inc == CW'(SETTLE)) begin
                  state_nx = S_SEARCH;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
            S_LOCKED: begin
               if (match) begin
                  cnt_nx = '0;
               end else if (cnt_inc == CW'(UNLOCK_COUNT)) begin
                  state_nx = S_SEARCH;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
            default: state_nx = S_SEARCH;
         endcase
      end
   end

   // A realign on a tick suppresses that tick's strobe and error pulse.
   always_comb begin
      wv_nx = tick && !realign && (state == S_LOCKED);
      fe_nx = wv_nx && !match;
   end

   always_ff @(posedge dco_clk) begin
      if (rst) begin
         words      <= '0;
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         locked     <= 1'b0;
      end else begin
         word_valid <= wv_nx;
         frame_err  <= fe_nx;
         locked     <= (state_nx == S_LOCKED);
         if (wv_nx) words <= words_nx;
      end
   end
endmodule
